sap_prog_ram: RTL and testbench
===============================

// Module: sap_prog_ram
// PURPOSE
//  Parametrised SAP program/data memory, successor to the fixed 16x8 ROM. Synchronous RAM with a boot
//  FSM that copies a built-in image into RAM after reset, a byte-stream PROG mode for reloading
//  programs, and a RUN-mode write port for STA-style stores. Sits on the W bus, addressed by the MAR.
// PARAMETERS
//  ADDR_W   4   address width; DEPTH = 1<<ADDR_W words
//  DATA_W   8   word width
//  USE_BOOT 1   1: copy BOOT_IMAGE after reset; 0: skip straight to RUN (contents undefined)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  addr       in   ADDR_W  read/write address from MAR
//  oe_n       in   1       active-low output enable onto bus
//  we         in   1       RUN-mode write strobe (active-high)
//  wr_data    in   DATA_W  RUN-mode write data
//  data       out  DATA_W  tri-state bus drive
//  prog_req   in   1       request/hold PROG mode
//  load_valid in   1       PROG stream word valid
//  load_data  in   DATA_W  PROG stream word
//  load_ready out  1       PROG stream ready
//  prog_addr  out  ADDR_W  next PROG write address
//  prog_done  out  1       1-cycle pulse: DEPTH-th word accepted in current PROG session
//  busy       out  1       1 in BOOT or PROG
// BEHAVIOUR
//  - States: BOOT, RUN, PROG. rst -> BOOT (USE_BOOT=1) or RUN (USE_BOOT=0), every cycle rst is high.
//  - Reset values: data=Z, load_ready=0, prog_addr=0, prog_done=0, busy=USE_BOOT, rd_q=0, boot_ptr=0.
//  - BOOT: each cycle mem[boot_ptr]<=BOOT_IMAGE[boot_ptr], boot_ptr++. After writing DEPTH-1 -> RUN
//    (DEPTH cycles total). we, prog_req, load_valid ignored; data=Z.
//  - RUN: rd_q<=mem[addr] every cycle (1-cycle read latency). data = oe_n ? Z : rd_q (oe_n gating
//    combinational). we=1 -> mem[addr]<=wr_data; same-cycle read returns OLD word (read-before-write).
//  - RUN -> PROG when prog_req=1; prog_addr cleared to 0 on entry; data=Z, we ignored in PROG.
//  - PROG: load_ready=1. Accept when load_valid&load_ready: mem[prog_addr]<=load_data, prog_addr++
//    mod DEPTH (wrap; further words overwrite from 0). prog_done pulses the cycle after the accept
//    that writes address DEPTH-1 (once per wrap).
//  - PROG -> RUN when prog_req=0; an accept in that same cycle still completes. load_ready=0 in RUN.
//  - rst mid-PROG/BOOT: abandon, restart BOOT at 0; BOOT_IMAGE overwrites loaded contents.
//  - rd_q holds last value outside RUN; first RUN read valid one cycle after entering RUN.
//  - All widths exact; address arithmetic modulo DEPTH, no overflow flags.
// STRUCTURE
//  - Package sap_pkg: opcode constants (LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF), state
//    enum {BOOT,RUN,PROG}, function boot_image(idx) returning default 16-entry program:
//    0:09 1:1A 2:1B 3:2C 4:E0 5:2D 6:E0 7:F0 8:00 9:10 A:14 B:18 C:20 D:08 E:00 F:00;
//    indices >=16 return 0.
//  - One sub-module: sap_ram_core (1R/1W sync RAM, read-before-write), FSM and bus drive in top.
// TESTING
//  - rst 1 cycle, wait 16 cycles: busy 1->0 at cycle 16; then addr=0..F, oe_n=0 -> data 09,1A,...,00
//    each one cycle after addr.
//  - RUN, oe_n=1 any addr -> data=ZZ; oe_n=0 same cycle -> rd_q drives immediately.
//  - RUN we=1 addr=E wr_data=55 with oe_n=0 -> next-cycle data=00 (old); following read addr=E -> 55.
//  - prog_req=1, stream 16 words AA..B9 with load_valid toggling 1/0 -> 16 accepts, prog_done pulse
//    after 16th, prog_addr wraps to 0; prog_req=0, read addr 3 -> AD.
//  - PROG, 5 words loaded, assert rst -> BOOT restarts, after 16 cycles addr=1 -> 1A (image restored).
//  - BOOT active: prog_req=1, we=1, load_valid=1 -> load_ready=0, no writes; enters PROG only after RUN.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program/data memory: opcodes, control states, boot program.
// Imported by the interface consumers and the memory top.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PROG = 2'd2
  } state_e;

  // Default program: LDA 9, ADD A, ADD B, SUB C, OUT, SUB D, OUT, HLT, then data words.
  function automatic logic [7:0] boot_image(input logic [31:0] idx);
    logic [7:0] val;
    case (idx)
      32'd0:   val = 8'h09;
      32'd1:   val = 8'h1A;
      32'd2:   val = 8'h1B;
      32'd3:   val = 8'h2C;
      32'd4:   val = 8'hE0;
      32'd5:   val = 8'h2D;
      32'd6:   val = 8'hE0;
      32'd7:   val = 8'hF0;
      32'd8:   val = 8'h00;
      32'd9:   val = 8'h10;
      32'd10:  val = 8'h14;
      32'd11:  val = 8'h18;
      32'd12:  val = 8'h20;
      32'd13:  val = 8'h08;
      32'd14:  val = 8'h00;
      32'd15:  val = 8'h00;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sap_prog_ram_if.sv
// Control, RUN-write and PROG-stream signals of the SAP program memory.
// data_en reports when the memory is driving the shared W bus.
interface sap_prog_ram_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              oe_n;
  logic              we;
  logic [DATA_W-1:0] wr_data;
  logic              prog_req;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [ADDR_W-1:0] prog_addr;
  logic              prog_done;
  logic              busy;
  logic              data_en;

  modport master (
    output addr, oe_n, we, wr_data, prog_req, load_valid, load_data,
    input  load_ready, prog_addr, prog_done, busy, data_en
  );

  modport slave (
    input  addr, oe_n, we, wr_data, prog_req, load_valid, load_data,
    output load_ready, prog_addr, prog_done, busy, data_en
  );
endinterface

// File: rtl/sap_ram_core.sv
// 1R/1W synchronous RAM with registered read; a read and write to the same address in one
// cycle returns the word held before the write.
module sap_ram_core #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_dat
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem[raddr];
  end

  // Array contents are not reset; the boot copy provides defined contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_dat = rd_q;
endmodule

// File: rtl/sap_prog_ram.sv
// SAP program/data memory: boot copy of the built-in image, RUN read/store port on the W bus,
// and a valid/ready byte stream for reloading programs while prog_req is held.
module sap_prog_ram
  import sap_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter bit USE_BOOT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sap_prog_ram_if.slave     bus,
  output tri [DATA_W-1:0]   data
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam state_e RST_STATE = USE_BOOT ? ST_BOOT : ST_RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] boot_ptr_q, boot_ptr_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic              prog_done_q, prog_done_d;
  logic              busy_q, busy_d;
  logic              load_ready_q, load_ready_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic              accept;
  logic [DATA_W-1:0] rd_dat;
  logic              data_en;

  always_comb begin
    state_d     = state_q;
    boot_ptr_d  = boot_ptr_q;
    prog_addr_d = prog_addr_q;
    prog_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = bus.addr;
    mem_wdata   = bus.wr_data;
    rd_en       = 1'b0;
    accept      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        mem_we     = 1'b1;
        mem_waddr  = boot_ptr_q;
        mem_wdata  = DATA_W'(boot_image(32'(boot_ptr_q)));
        boot_ptr_d = boot_ptr_q + 1'b1;
        if (boot_ptr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_en  = 1'b1;
        mem_we = bus.we;
        if (bus.prog_req) begin
          state_d     = ST_PROG;
          prog_addr_d = '0;
        end
      end
      ST_PROG: begin
        // A word offered in the cycle prog_req drops is still written.
        accept = bus.load_valid & load_ready_q;
        if (accept) begin
          mem_we      = 1'b1;
          mem_waddr   = prog_addr_q;
          mem_wdata   = bus.load_data;
          prog_addr_d = prog_addr_q + 1'b1;
          prog_done_d = (prog_addr_q == LAST_ADDR);
        end
        if (!bus.prog_req) state_d = ST_RUN;
      end
      default: state_d = RST_STATE;
    endcase

    busy_d       = (state_d != ST_RUN);
    load_ready_d = (state_d == ST_PROG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_STATE;
      boot_ptr_q   <= '0;
      prog_addr_q  <= '0;
      prog_done_q  <= 1'b0;
      busy_q       <= USE_BOOT;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_ptr_q   <= boot_ptr_d;
      prog_addr_q  <= prog_addr_d;
      prog_done_q  <= prog_done_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
    end
  end

  sap_ram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .re     (rd_en),
    .raddr  (bus.addr),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .rd_dat (rd_dat)
  );

  // Bus drive gated combinationally by oe_n, only while the CPU owns the memory.
  assign data_en = (state_q == ST_RUN) & ~bus.oe_n;
  assign data    = data_en ? rd_dat : {DATA_W{1'bz}};

  assign bus.data_en    = data_en;
  assign bus.load_ready = load_ready_q;
  assign bus.prog_addr  = prog_addr_q;
  assign bus.prog_done  = prog_done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sap_prog_ram.sv
// Randomized bench for sap_prog_ram against an array model of memory contents.
module tb_sap_prog_ram;
  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] data;
  int         total = 0;
  int         bad   = 0;

  logic [7:0] img [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'h2D, 8'hE0, 8'hF0,
                           8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h08, 8'h00, 8'h00};
  logic [7:0] model [16];

  sap_prog_ram_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

  sap_prog_ram #(.ADDR_W(4), .DATA_W(8), .USE_BOOT(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc),
    .data (data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ifc.addr       = '0;
    ifc.oe_n       = 1'b1;
    ifc.we         = 1'b0;
    ifc.wr_data    = '0;
    ifc.prog_req   = 1'b0;
    ifc.load_valid = 1'b0;
    ifc.load_data  = '0;
  endtask

  // Reset has just been released; the image copy must take exactly 16 cycles.
  // With disturb set, every control input is held active and must have no effect.
  task automatic boot_phase(input bit disturb);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      ifc.oe_n       = 1'b0;
      ifc.prog_req   = disturb;
      ifc.we         = disturb;
      ifc.load_valid = disturb;
      ifc.addr       = 4'(cyc);
      ifc.wr_data    = 8'($urandom);
      ifc.load_data  = 8'($urandom);
      #1;
      check_eq("boot_no_drive", ifc.data_en, 0);
      tick();
      check_eq("boot_busy", ifc.busy, (cyc < 16) ? 1 : 0);
      check_eq("boot_load_ready", ifc.load_ready, 0);
    end
    ifc.we         = 1'b0;
    ifc.load_valid = 1'b0;
    model = img;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      ifc.addr = 4'(a);
      ifc.oe_n = 1'b0;
      ifc.we   = 1'b0;
      tick();
      check_eq({tag, "_en"}, ifc.data_en, 1);
      check_eq(tag, data, model[a]);
    end
  endtask

  task automatic random_run(input int n);
    logic [7:0] exp_rd;
    bit         have_prev;
    have_prev = 1'b0;
    exp_rd    = '0;
    for (int i = 0; i < n; i++) begin
      logic [3:0] a;
      logic       oe, w;
      logic [7:0] wd;
      a  = 4'($urandom_range(0, 15));
      oe = 1'($urandom);
      w  = ($urandom_range(0, 3) == 0);
      wd = 8'($urandom);
      ifc.addr = a; ifc.oe_n = oe; ifc.we = w; ifc.wr_data = wd;
      #1;
      check_eq("run_oe", ifc.data_en, {31'b0, ~oe});
      if (!oe && have_prev) check_eq("run_read", data, exp_rd);
      tick();
      exp_rd = model[a];
      if (w) model[a] = wd;
      have_prev = 1'b1;
    end
    ifc.we = 1'b0;
  endtask

  task automatic prog_session(input bit directed, input int ncyc);
    int k;
    ifc.prog_req = 1'b1;
    ifc.oe_n     = 1'b0;
    ifc.we       = 1'b1;
    ifc.wr_data  = 8'($urandom);
    tick();
    check_eq("prog_entry_ready", ifc.load_ready, 1);
    check_eq("prog_entry_addr", ifc.prog_addr, 0);
    check_eq("prog_entry_busy", ifc.busy, 1);
    k = 0;
    for (int i = 0; i < ncyc; i++) begin
      logic       v;
      logic [7:0] d;
      logic       exp_done;
      v = directed ? (i % 2 == 0) : 1'($urandom);
      d = directed ? 8'(8'hAA + k) : 8'($urandom);
      ifc.load_valid = v;
      ifc.load_data  = d;
      ifc.addr       = 4'($urandom);
      #1;
      check_eq("prog_no_drive", ifc.data_en, 0);
      tick();
      exp_done = 1'b0;
      if (v) begin
        model[k % 16] = d;
        exp_done = (k % 16 == 15);
        k++;
      end
      check_eq("prog_done", ifc.prog_done, exp_done);
      check_eq("prog_addr", ifc.prog_addr, k % 16);
    end
    if (directed) check_eq("prog_accepts", k, 16);
    ifc.prog_req   = 1'b0;
    ifc.load_valid = !directed;
    ifc.load_data  = 8'($urandom);
    tick();
    if (!directed) begin
      model[k % 16] = ifc.load_data;
      check_eq("exit_done", ifc.prog_done, (k % 16 == 15) ? 1 : 0);
    end
    check_eq("exit_ready", ifc.load_ready, 0);
    check_eq("exit_busy", ifc.busy, 0);
    ifc.load_valid = 1'b0;
    ifc.we         = 1'b0;
  endtask

  initial begin
    drive_idle();
    ifc.oe_n = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("rst_busy", ifc.busy, 1);
    check_eq("rst_load_ready", ifc.load_ready, 0);
    check_eq("rst_prog_addr", ifc.prog_addr, 0);
    check_eq("rst_prog_done", ifc.prog_done, 0);
    check_eq("rst_no_drive", ifc.data_en, 0);
    rst = 1'b0;
    boot_phase(1'b0);
    read_all("boot_read");

    // Store with a same-cycle read of the same word returns the old value.
    ifc.addr = 4'hE; ifc.we = 1'b1; ifc.wr_data = 8'h55; ifc.oe_n = 1'b0;
    tick();
    check_eq("rbw_old", data, model[14]);
    model[14] = 8'h55;
    ifc.we = 1'b0;
    tick();
    check_eq("rbw_new", data, 8'h55);
    ifc.oe_n = 1'b1;
    #1;
    check_eq("oe_off", ifc.data_en, 0);
    ifc.oe_n = 1'b0;
    #1;
    check_eq("oe_on", ifc.data_en, 1);
    check_eq("oe_on_data", data, 8'h55);

    random_run(80);
    prog_session(1'b1, 32);
    read_all("prog_read");
    random_run(40);
    prog_session(1'b0, 45);
    read_all("prog2_read");

    // Reset in the middle of a load restores the boot image.
    ifc.prog_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ifc.load_valid = 1'b1;
      ifc.load_data  = 8'($urandom);
      tick();
    end
    check_eq("mid_prog_addr", ifc.prog_addr, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_prog_addr", ifc.prog_addr, 0);
    check_eq("rst2_load_ready", ifc.load_ready, 0);
    boot_phase(1'b1);
    tick();
    check_eq("late_prog_ready", ifc.load_ready, 1);
    check_eq("late_prog_busy", ifc.busy, 1);
    ifc.prog_req = 1'b0;
    tick();
    check_eq("late_prog_exit", ifc.busy, 0);
    read_all("reboot_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
